// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a captured pattern out MSB-first, repeated
// rep+1 times, with registered x/valid/busy/done outputs.
module seq_gen #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH):0]   len,
    input  logic [3:0]               rep,
    output logic                     x,
    output logic                     valid,
    output logic                     busy,
    output logic                     done
);

    localparam int LW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       rep_cnt_q, rep_cnt_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LW-1:0]    len_clamp;
    logic [WIDTH-1:0] aligned;

    // The pattern is stored left-aligned so the next bit is always the MSB,
    // whatever len was; bit_cnt counts bits still to come in this repetition.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        sr_d      = sr_q;
        pat_d     = pat_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        x_d       = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        len_clamp = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
        aligned   = pattern << (WIDTH - int'(len_clamp));

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d     = aligned;
                    len_d     = len_clamp;
                    rep_cnt_d = rep;
                    busy_d    = 1'b1;
                    if (len_clamp == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = SHIFT;
                        x_d       = aligned[WIDTH-1];
                        sr_d      = aligned << 1;
                        bit_cnt_d = len_clamp - LW'(1);
                        valid_d   = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                    rep_cnt_d = '0;
                end else if (bit_cnt_q != '0) begin
                    x_d       = sr_q[WIDTH-1];
                    sr_d      = sr_q << 1;
                    bit_cnt_d = bit_cnt_q - LW'(1);
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else if (rep_cnt_q != 4'd0) begin
                    // Next repetition starts immediately, no gap cycle.
                    x_d       = pat_q[WIDTH-1];
                    sr_d      = pat_q << 1;
                    bit_cnt_d = len_q - LW'(1);
                    rep_cnt_d = rep_cnt_q - 4'd1;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            DONE: begin
                state_d   = IDLE;
                sr_d      = '0;
                bit_cnt_d = '0;
                rep_cnt_d = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen (WIDTH=8): serial streams,
// repetitions, len clamping, ignored starts, abort and asynchronous reset.
module tb_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;

    int total;
    int passed;

    seq_gen #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .rep     (rep),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Outputs are sampled at the falling edge, mid-cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".outs"}, {12'd0, x, valid, busy, done}, 16'h0000);
    endtask

    task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p;
        len     = l;
        rep     = r;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Checks n contiguous valid bits (MSB of the n-bit stream first), then
    // the single DONE cycle, then the return to IDLE.
    task automatic expect_stream(input logic [15:0] s, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.bit%0d", tag, i), {12'd0, x, valid, busy, done},
                  {12'd0, s[n-1-i], 1'b1, 1'b1, 1'b0});
            step();
        end
        check({tag, ".done"}, {12'd0, x, valid, busy, done}, 16'h0003);
        step();
        check_idle({tag, ".idle"});
    endtask

    initial begin
        logic [7:0] s4;
        logic [7:0] s5;
        total   = 0;
        passed  = 0;
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 8'h00;
        len     = 4'd0;
        rep     = 4'd0;

        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        step();
        check_idle("post_reset");

        // Scenario 1: single 8-bit pattern, busy 9 cycles.
        send(8'b0100_1010, 4'd8, 4'd0);
        expect_stream(16'b0100_1010, 8, "s1");

        // Scenario 2: 4-bit pattern sent three times back to back.
        send(8'h0B, 4'd4, 4'd2);
        expect_stream(16'b1011_1011_1011, 12, "s2");

        // Scenario 3: len=0 goes straight to DONE; len=12 clamps to 8.
        send(8'hA5, 4'd0, 4'd3);
        check("s3.len0_done", {12'd0, x, valid, busy, done}, 16'h0003);
        step();
        check_idle("s3.len0_idle");
        send(8'hA5, 4'd12, 4'd0);
        expect_stream(16'b1010_0101, 8, "s3.clamp");

        // Scenario 4: start re-pulsed and inputs changed during the transfer.
        s4 = 8'b1100_0011;
        send(s4, 4'd8, 4'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s4.bit%0d", i), {12'd0, x, valid, busy, done},
                  {12'd0, s4[7-i], 1'b1, 1'b1, 1'b0});
            if (i == 2) begin
                start   = 1'b1;
                pattern = 8'h00;
                len     = 4'd3;
                rep     = 4'd5;
            end
            step();
        end
        check("s4.done", {12'd0, x, valid, busy, done}, 16'h0003);
        step();
        check_idle("s4.not_queued");
        start = 1'b0;
        step();
        check_idle("s4.still_idle");

        // Scenario 5: abort after three bits, then start+abort in IDLE.
        s5 = 8'b1011_0100;
        send(s5, 4'd8, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("s5.bit%0d", i), {12'd0, x, valid, busy, done},
                  {12'd0, s5[7-i], 1'b1, 1'b1, 1'b0});
            if (i < 2) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("s5.aborted");
        step();
        check_idle("s5.no_done");
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_idle("s5.abort_wins");
        step();
        check_idle("s5.abort_wins2");

        // Scenario 6: asynchronous reset mid-transfer, then a fresh transfer.
        send(8'h5A, 4'd8, 4'd1);
        step();
        check("s6.running", {15'd0, busy}, 16'h0001);
        #2 rst = 1'b0;
        #1 check_idle("s6.async_reset");
        step();
        check_idle("s6.held_reset");
        rst = 1'b1;
        send(8'hFF, 4'd8, 4'd0);
        expect_stream(16'h00FF, 8, "s6.after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
